// File: rtl/pc_controller.sv
// Program-counter controller with a circular return-address stack and trap/EPC handling.
// Computed branch/return targets with bit 1 set are redirected to TRAP_VECTOR.
module pc_controller #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100),
   parameter int              RAS_DEPTH    = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pcWriteEnable,
   input  logic [2:0]      pcOp,
   input  logic [XLEN-1:0] pcWriteData,
   output logic [XLEN-1:0] pcReadData,
   output logic [XLEN-1:0] pcPlus4,
   output logic [XLEN-1:0] epcReadData,
   output logic            misaligned,
   output logic            rasEmpty,
   output logic            rasFull
);

   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = $clog2(RAS_DEPTH + 1);

   typedef enum logic [2:0] {
      OP_SEQ  = 3'd0,
      OP_REL  = 3'd1,
      OP_ABS  = 3'd2,
      OP_TRAP = 3'd3,
      OP_CALL = 3'd4,
      OP_RET  = 3'd5
   } pcOpT;

   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] epc;
   logic            misReg;
   logic [XLEN-1:0] rasMem [RAS_DEPTH];
   logic [PW-1:0]   rasPtr;
   logic [CW-1:0]   rasCount;

   logic [XLEN-1:0] pcInc;
   logic [XLEN-1:0] target;
   logic [XLEN-1:0] nextPc;
   logic [PW-1:0]   topIdx;
   logic            checkTarget;
   logic            trapNow;
   logic            misNext;
   logic            doPush;
   logic            doPop;
   logic            countEmpty;
   logic            countFull;

   assign pcInc       = pc + XLEN'(4);
   assign topIdx      = rasPtr - PW'(1);
   assign countEmpty  = (rasCount == '0);
   assign countFull   = (rasCount == CW'(RAS_DEPTH));

   assign pcReadData  = pc;
   assign pcPlus4     = pcInc;
   assign epcReadData = epc;
   assign misaligned  = misReg;
   assign rasEmpty    = countEmpty;
   assign rasFull     = countFull;

   // Decode the operation into a next PC plus RAS push/pop and trap requests.
   always_comb begin
      target      = '0;
      nextPc      = pc;
      checkTarget = 1'b0;
      trapNow     = 1'b0;
      misNext     = 1'b0;
      doPush      = 1'b0;
      doPop       = 1'b0;
      case (pcOp)
         OP_SEQ: nextPc = pcInc;
         OP_REL: begin
            target      = pc + pcWriteData;
            checkTarget = 1'b1;
         end
         OP_ABS: begin
            target      = pcWriteData & ~XLEN'(1);
            checkTarget = 1'b1;
         end
         OP_TRAP: trapNow = 1'b1;
         OP_CALL: begin
            target      = pc + pcWriteData;
            checkTarget = 1'b1;
            doPush      = ~target[1];
         end
         OP_RET: begin
            checkTarget = 1'b1;
            if (!countEmpty) begin
               target = rasMem[topIdx];
               doPop  = 1'b1;
            end else begin
               target = pcWriteData & ~XLEN'(1);
            end
         end
         default: ;
      endcase
      if (checkTarget) begin
         if (target[1]) begin
            trapNow = 1'b1;
            misNext = 1'b1;
         end else begin
            nextPc = target;
         end
      end
      if (trapNow) nextPc = TRAP_VECTOR;
   end

   // Architectural state: PC, EPC, misalignment pulse and RAS bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc       <= RESET_VECTOR;
         epc      <= '0;
         misReg   <= 1'b0;
         rasPtr   <= '0;
         rasCount <= '0;
      end else if (pcWriteEnable) begin
         pc     <= nextPc;
         misReg <= misNext;
         if (trapNow) epc <= pc;
         if (doPush) begin
            rasPtr <= rasPtr + PW'(1);
            if (!countFull) rasCount <= rasCount + CW'(1);
         end else if (doPop) begin
            rasPtr   <= topIdx;
            rasCount <= rasCount - CW'(1);
         end
      end else begin
         misReg <= 1'b0;
      end
   end

   // Entry storage is not reset; a full stack simply overwrites its oldest slot.
   always_ff @(posedge clk) begin
      if (!rst && pcWriteEnable && doPush) rasMem[rasPtr] <= pcInc;
   end

endmodule

// File: tb/tb_pc_controller.sv
// Directed testbench for pc_controller: hand-computed PC, EPC and RAS sequences.
module tb_pc_controller;

   logic        clk;
   logic        rst;
   logic        pcWriteEnable;
   logic [2:0]  pcOp;
   logic [31:0] pcWriteData;
   logic [31:0] pcReadData;
   logic [31:0] pcPlus4;
   logic [31:0] epcReadData;
   logic        misaligned;
   logic        rasEmpty;
   logic        rasFull;

   int total = 0;
   int bad   = 0;

   localparam logic [2:0] SEQ = 3'd0, REL = 3'd1, ABS = 3'd2, TRAP = 3'd3,
                          CALL = 3'd4, RET = 3'd5;

   pc_controller #(.XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100), .RAS_DEPTH(4)) dut (
      .clk(clk),
      .rst(rst),
      .pcWriteEnable(pcWriteEnable),
      .pcOp(pcOp),
      .pcWriteData(pcWriteData),
      .pcReadData(pcReadData),
      .pcPlus4(pcPlus4),
      .epcReadData(epcReadData),
      .misaligned(misaligned),
      .rasEmpty(rasEmpty),
      .rasFull(rasFull)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input logic r, input logic we, input logic [2:0] op,
                                input logic [31:0] data);
      @(negedge clk);
      rst           = r;
      pcWriteEnable = we;
      pcOp          = op;
      pcWriteData   = data;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic checkPc(input string tag, input logic [31:0] expPc, input logic expMis);
      checkOutput({tag, ".pc"}, pcReadData, expPc);
      checkOutput({tag, ".mis"}, 32'(misaligned), 32'(expMis));
   endtask

   initial begin
      rst = 1'b1; pcWriteEnable = 1'b0; pcOp = SEQ; pcWriteData = '0;

      // Reset state
      applyStimulus(1'b1, 1'b1, SEQ, 32'h0);
      checkPc("reset", 32'h0, 1'b0);
      checkOutput("reset.epc", epcReadData, 32'h0);
      checkOutput("reset.rasEmpty", 32'(rasEmpty), 32'h1);
      checkOutput("reset.rasFull", 32'(rasFull), 32'h0);
      checkOutput("reset.pcPlus4", pcPlus4, 32'h4);

      // Sequential stepping
      applyStimulus(1'b0, 1'b1, SEQ, 32'h0);  checkPc("seq1", 32'h4, 1'b0);
      applyStimulus(1'b0, 1'b1, SEQ, 32'h0);  checkPc("seq2", 32'h8, 1'b0);
      applyStimulus(1'b0, 1'b1, SEQ, 32'h0);  checkPc("seq3", 32'hC, 1'b0);
      checkOutput("seq3.pcPlus4", pcPlus4, 32'h10);

      // Call then return
      applyStimulus(1'b0, 1'b1, ABS, 32'h8);   checkPc("abs8", 32'h8, 1'b0);
      applyStimulus(1'b0, 1'b1, CALL, 32'h20); checkPc("call", 32'h28, 1'b0);
      checkOutput("call.rasEmpty", 32'(rasEmpty), 32'h0);
      applyStimulus(1'b0, 1'b1, RET, 32'h0);   checkPc("ret", 32'hC, 1'b0);
      checkOutput("ret.rasEmpty", 32'(rasEmpty), 32'h1);

      // Five calls into a 4-deep RAS: pushes 10,20,30,40,50; 10 is discarded
      applyStimulus(1'b0, 1'b1, CALL, 32'h10); checkPc("callA", 32'h1C, 1'b0);
      applyStimulus(1'b0, 1'b1, CALL, 32'h10); checkPc("callB", 32'h2C, 1'b0);
      applyStimulus(1'b0, 1'b1, CALL, 32'h10); checkPc("callC", 32'h3C, 1'b0);
      applyStimulus(1'b0, 1'b1, CALL, 32'h10); checkPc("callD", 32'h4C, 1'b0);
      checkOutput("callD.rasFull", 32'(rasFull), 32'h1);
      applyStimulus(1'b0, 1'b1, CALL, 32'h10); checkPc("callE", 32'h5C, 1'b0);
      checkOutput("callE.rasFull", 32'(rasFull), 32'h1);
      applyStimulus(1'b0, 1'b1, RET, 32'h40);  checkPc("retE", 32'h50, 1'b0);
      checkOutput("retE.rasFull", 32'(rasFull), 32'h0);
      applyStimulus(1'b0, 1'b1, RET, 32'h40);  checkPc("retD", 32'h40, 1'b0);
      applyStimulus(1'b0, 1'b1, RET, 32'h40);  checkPc("retC", 32'h30, 1'b0);
      applyStimulus(1'b0, 1'b1, RET, 32'h40);  checkPc("retB", 32'h20, 1'b0);
      checkOutput("retB.rasEmpty", 32'(rasEmpty), 32'h1);
      applyStimulus(1'b0, 1'b1, RET, 32'h41);  checkPc("retEmpty", 32'h40, 1'b0);
      checkOutput("retEmpty.rasEmpty", 32'(rasEmpty), 32'h1);

      // Misaligned absolute targets
      applyStimulus(1'b0, 1'b1, ABS, 32'h10);  checkPc("abs10", 32'h10, 1'b0);
      applyStimulus(1'b0, 1'b1, ABS, 32'h22);  checkPc("abs22", 32'h100, 1'b1);
      checkOutput("abs22.epc", epcReadData, 32'h10);
      applyStimulus(1'b0, 1'b1, SEQ, 32'h0);   checkPc("afterMis", 32'h104, 1'b0);
      applyStimulus(1'b0, 1'b1, ABS, 32'h10);  checkPc("abs10b", 32'h10, 1'b0);
      applyStimulus(1'b0, 1'b1, ABS, 32'h23);  checkPc("abs23", 32'h100, 1'b1);
      checkOutput("abs23.epc", epcReadData, 32'h10);
      applyStimulus(1'b0, 1'b0, ABS, 32'h23);  checkPc("stallClearsMis", 32'h100, 1'b0);

      // Explicit trap
      applyStimulus(1'b0, 1'b1, ABS, 32'h200); checkPc("abs200", 32'h200, 1'b0);
      applyStimulus(1'b0, 1'b1, TRAP, 32'h8);  checkPc("trap", 32'h100, 1'b0);
      checkOutput("trap.epc", epcReadData, 32'h200);

      // Relative branches, negative offset and misaligned result
      applyStimulus(1'b0, 1'b1, REL, 32'hFFFFFFF8); checkPc("relNeg", 32'hF8, 1'b0);
      applyStimulus(1'b0, 1'b1, REL, 32'h2);        checkPc("relMis", 32'h100, 1'b1);
      checkOutput("relMis.epc", epcReadData, 32'hF8);

      // Misaligned call does not push; misaligned empty return traps
      applyStimulus(1'b0, 1'b1, CALL, 32'h6);  checkPc("callMis", 32'h100, 1'b1);
      checkOutput("callMis.rasEmpty", 32'(rasEmpty), 32'h1);
      checkOutput("callMis.epc", epcReadData, 32'h100);
      applyStimulus(1'b0, 1'b1, RET, 32'h6);   checkPc("retMis", 32'h100, 1'b1);
      checkOutput("retMis.rasEmpty", 32'(rasEmpty), 32'h1);

      // Stall holds state
      applyStimulus(1'b0, 1'b0, REL, 32'h100); checkPc("stall1", 32'h100, 1'b0);
      applyStimulus(1'b0, 1'b0, REL, 32'h100); checkPc("stall2", 32'h100, 1'b0);
      applyStimulus(1'b0, 1'b0, REL, 32'h100); checkPc("stall3", 32'h100, 1'b0);

      // Reset wins over a concurrent call
      applyStimulus(1'b0, 1'b1, CALL, 32'h10); checkPc("callPreRst", 32'h110, 1'b0);
      checkOutput("callPreRst.rasEmpty", 32'(rasEmpty), 32'h0);
      applyStimulus(1'b1, 1'b1, CALL, 32'h10); checkPc("rstCall", 32'h0, 1'b0);
      checkOutput("rstCall.rasEmpty", 32'(rasEmpty), 32'h1);
      checkOutput("rstCall.epc", epcReadData, 32'h0);

      // Wraparound at the top of the address space
      applyStimulus(1'b0, 1'b1, ABS, 32'hFFFFFFFC); checkPc("absTop", 32'hFFFFFFFC, 1'b0);
      checkOutput("absTop.pcPlus4", pcPlus4, 32'h0);
      applyStimulus(1'b0, 1'b1, SEQ, 32'h0);        checkPc("seqWrap", 32'h0, 1'b0);

      // Reserved opcodes hold the PC
      applyStimulus(1'b0, 1'b1, 3'd6, 32'h40); checkPc("op6", 32'h0, 1'b0);
      applyStimulus(1'b0, 1'b1, 3'd7, 32'h40); checkPc("op7", 32'h0, 1'b0);
      checkOutput("op7.rasEmpty", 32'(rasEmpty), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
